// File: rtl/picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_mem_responder
// Description : picorv32 native-bus slave RAM with programmable wait states,
//               byte-lane writes and a saturating transaction counter.
//               Define MEM_RESPONDER_PROTO_CHECK_EN to build the sticky
//               bus-protocol checker (proto_err is tied low otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  input  logic                mem_instr,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  input  logic [3:0]          wait_cfg,
  output logic                busy,
  output logic [CNT_BITS-1:0] txn_count,
  output logic                proto_err
);

  localparam int c_DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_wcnt;
  logic [3:0]           w_wcnt_nxt;
  logic                 w_accept;
  logic [ADDR_BITS-1:0] r_idx;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [CNT_BITS-1:0]  r_txn_count;
  logic [31:0]          r_mem [0:c_DEPTH-1];

  always_comb begin
    w_next     = r_state;
    w_wcnt_nxt = r_wcnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_accept   = 1'b1;
          w_wcnt_nxt = wait_cfg;
          w_next     = (wait_cfg != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt == 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_wcnt      <= 4'd0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_txn_count <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_nxt;
      if (w_accept) begin
        r_idx   <= mem_addr[ADDR_BITS+1:2];
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
      end
      if (r_state == S_RESP && r_txn_count != {CNT_BITS{1'b1}}) begin
        r_txn_count <= r_txn_count + 1'b1;
      end
    end
  end

  // RAM has no reset; the write commits on the edge that ends the RESP cycle.
  always_ff @(posedge clk) begin
    if (resetn && r_state == S_RESP) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_ready = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign txn_count = r_txn_count;
  assign mem_rdata = (r_state == S_RESP && r_wstrb == 4'd0) ? r_mem[r_idx] : 32'd0;

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  logic [31:0] r_addr;
  logic        r_instr;
  logic        r_proto_err;
  logic        w_violation;

  // Any drop or change of the request while it is outstanding is a violation.
  always_comb begin
    w_violation = (r_state != S_IDLE) &&
                  (!mem_valid || mem_addr != r_addr || mem_wdata != r_wdata ||
                   mem_wstrb != r_wstrb || mem_instr != r_instr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= 32'd0;
      r_instr     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= mem_addr;
        r_instr <= mem_instr;
      end
      if (w_violation) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign proto_err = r_proto_err;
`else
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, mem_instr, mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};
  assign proto_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_mem_responder
// Description : Directed plus randomized bench with a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_mem_responder;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  wait_cfg;
  logic        busy;
  logic [15:0] txn_count;
  logic        proto_err;

  picorv32_mem_responder #(.ADDR_BITS(10), .CNT_BITS(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .wait_cfg  (wait_cfg),
    .busy      (busy),
    .txn_count (txn_count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [0:1023];
  int          exp_cnt = 0;
  logic        exp_pe  = 1'b0;
  int          pool [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % 1024);
  endfunction

  // One full bus transaction; optionally rewrites wait_cfg or perturbs the
  // address one cycle after acceptance.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [3:0] n,
                     input int mid_cfg, input bit perturb);
    int          k;
    bit          seen;
    int          w;
    logic [31:0] exp_rd;
    w      = word_of(addr);
    exp_rd = (strb == 4'd0) ? model[w] : 32'd0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    mem_instr = 1'b0;
    wait_cfg  = n;
    @(posedge clk); #1;
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 40) begin
      chk("busy_during", 32'(busy), 32'd1);
      if (mem_ready) begin
        seen = 1'b1;
        chk("latency", 32'(k), 32'(int'(n) + 1));
        chk("rdata", mem_rdata, exp_rd);
      end else begin
        chk("rdata_not_ready", mem_rdata, 32'd0);
      end
      if (perturb && k == 1) chk("proto_pre", 32'(proto_err), 32'(exp_pe));
      if (perturb && k == 2) begin
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        exp_pe = 1'b1;
`endif
        chk("proto_rise", 32'(proto_err), 32'(exp_pe));
      end
      if (k == 1 && mid_cfg >= 0) wait_cfg = mid_cfg[3:0];
      if (k == 1 && perturb) mem_addr = addr + 32'd4;
      if (!seen) begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) model[w][8*i +: 8] = wdata[8*i +: 8];
    end
    if (exp_cnt < 65535) exp_cnt++;
    @(posedge clk); #1;
    chk("ready_after", 32'(mem_ready), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("txn_count", 32'(txn_count), 32'(exp_cnt));
    chk("proto_err", 32'(proto_err), 32'(exp_pe));
  endtask

  initial begin
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    wait_cfg  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(txn_count), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Write then read back with zero wait states
    txn(32'h10, 32'hDEADBEEF, 4'hF, 4'd0, -1, 1'b0);
    txn(32'h10, 32'h0, 4'h0, 4'd0, -1, 1'b0);
    chk("count_two", 32'(txn_count), 32'd2);

    // wait_cfg changed mid-WAIT only affects the next request
    txn(32'h10, 32'h0, 4'h0, 4'd5, 3, 1'b0);
    txn(32'h10, 32'h0, 4'h0, 4'd3, -1, 1'b0);

    // Byte lanes
    txn(32'h20, 32'h11223344, 4'hF, 4'd1, -1, 1'b0);
    txn(32'h20, 32'hAABBCCDD, 4'b0101, 4'd2, -1, 1'b0);
    txn(32'h20, 32'h0, 4'h0, 4'd0, -1, 1'b0);

    // Wrap and alignment
    txn(32'h1004, 32'h5A5A5A5A, 4'hF, 4'd0, -1, 1'b0);
    txn(32'h0006, 32'h0, 4'h0, 4'd1, -1, 1'b0);

    // Randomized traffic over a prewritten pool of words
    for (int i = 0; i < 16; i++) begin
      pool[i] = 64 + int'($urandom_range(0, 900));
      txn(32'(pool[i]) << 2, $urandom, 4'hF, 4'($urandom_range(0, 2)), -1, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = ($urandom & 32'hFFFF_F003) | (32'(pool[$urandom_range(0, 15)]) << 2);
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) s = 4'd0;
      txn(a, $urandom, s, 4'($urandom_range(0, 3)), -1, 1'b0);
    end

    // Address changed while the request is in WAIT
    txn(32'h40, 32'h40404040, 4'hF, 4'd0, -1, 1'b0);
    txn(32'h44, 32'h44444444, 4'hF, 4'd0, -1, 1'b0);
    txn(32'h40, 32'h0, 4'h0, 4'd4, -1, 1'b1);

    // Reset in the middle of a long write
    txn(32'h30, 32'h0BADF00D, 4'hF, 4'd0, -1, 1'b0);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h30;
    mem_wdata = 32'hFFFFFFFF;
    mem_wstrb = 4'hF;
    wait_cfg  = 4'd7;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      chk("midrst_ready", 32'(mem_ready), 32'd0);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    resetn = 1'b0;
    #1;
    chk("midrst_ready_low", 32'(mem_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(txn_count), 32'd0);
    chk("midrst_proto", 32'(proto_err), 32'd0);
    mem_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_ready", 32'(mem_ready), 32'd0);
    end
    @(negedge clk);
    resetn  = 1'b1;
    exp_cnt = 0;
    exp_pe  = 1'b0;
    txn(32'h30, 32'h0, 4'h0, 4'd2, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
